// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Index of the register that can be hard-wired to zero.
    localparam int ZERO_IDX = 0;

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: tracks pending writes, derives iss_ready, counts pending registers.
// Optional feature: REGFILE_BYPASS_EN masks a hazard when its writeback lands this cycle.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_dst,
    input  logic [ADDR_W-1:0]     iss_src_a,
    input  logic [ADDR_W-1:0]     iss_src_b,
    output logic                  iss_ready,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic [ADDR_W:0]       pend_cnt
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0] hazard;
    logic [NREGS-1:0] busy_nxt;
    logic             do_set;
    logic             same_idx;
    logic             cnt_inc;
    logic             cnt_dec;

    // Per-register hazard: busy, except the zero register and (with bypass) a register written now.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            hazard[r] = busy[r];
            if (ZERO_REG && r == ZERO_IDX) hazard[r] = 1'b0;
`ifdef REGFILE_BYPASS_EN
            if (wr_en && wr_addr == ADDR_W'(r)) hazard[r] = 1'b0;
`endif
        end
    end

    assign iss_ready = !(hazard[iss_src_a] | hazard[iss_src_b] | hazard[iss_dst]);

    // Issue claims the destination unless it is the hard-wired zero register.
    assign do_set   = iss_valid & iss_ready &
                      !(ZERO_REG && iss_dst == ADDR_W'(ZERO_IDX));
    assign same_idx = do_set & wr_en & (iss_dst == wr_addr);

    // Count only real bit transitions so pend_cnt always equals popcount(busy);
    // a same-index set/release leaves an already-busy bit set and counts as net 0.
    assign cnt_inc  = do_set & !busy[iss_dst];
    assign cnt_dec  = wr_en & busy[wr_addr] & !same_idx;

    // Next busy vector: release first, then set, so the set wins on a collision.
    always_comb begin
        busy_nxt = busy;
        if (wr_en)  busy_nxt[wr_addr] = 1'b0;
        if (do_set) busy_nxt[iss_dst] = 1'b1;
    end

    // Busy bits and pending counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            if (cnt_inc && !cnt_dec)      pend_cnt <= pend_cnt + (ADDR_W+1)'(1);
            else if (!cnt_inc && cnt_dec) pend_cnt <= pend_cnt - (ADDR_W+1)'(1);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with integrated busy-bit scoreboard.
// Optional feature: REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      rd_addr_a,
    input  logic [ADDR_W-1:0]      rd_addr_b,
    output logic [DATA_W-1:0]      rd_data_a,
    output logic [DATA_W-1:0]      rd_data_b,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_dst,
    input  logic [ADDR_W-1:0]      iss_src_a,
    input  logic [ADDR_W-1:0]      iss_src_b,
    output logic                   iss_ready,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic [ADDR_W:0]        pend_cnt
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_zero;
    logic              rd_zero_a;
    logic              rd_zero_b;

    assign wr_zero   = ZERO_REG && wr_addr   == ADDR_W'(ZERO_IDX);
    assign rd_zero_a = ZERO_REG && rd_addr_a == ADDR_W'(ZERO_IDX);
    assign rd_zero_b = ZERO_REG && rd_addr_b == ADDR_W'(ZERO_IDX);

    // Data array: async clear, writeback writes except into the zero register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else if (wr_en && !wr_zero) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read port A: zero register, optional writeback forward, else stored value.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == rd_addr_a) rd_data_a = wr_data;
`endif
        if (rd_zero_a) rd_data_a = '0;
    end

    // Read port B: same selection as port A.
    always_comb begin
        rd_data_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == rd_addr_b) rd_data_b = wr_data;
`endif
        if (rd_zero_b) rd_data_b = '0;
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .iss_src_a (iss_src_a),
        .iss_src_b (iss_src_b),
        .iss_ready (iss_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .pend_cnt  (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus randomized traffic against a
// behavioural model (plain arrays of register values and busy flags).
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam bit ZR = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          iss_valid = 1'b0;
    logic [AW-1:0] iss_dst = '0, iss_src_a = '0, iss_src_b = '0;
    logic          iss_ready;
    logic [NR-1:0] busy;
    logic [AW:0]   pend_cnt;

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_dst(iss_dst),
        .iss_src_a(iss_src_a), .iss_src_b(iss_src_b),
        .iss_ready(iss_ready), .busy(busy), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_is_zero(input int r);
        return ZR && r == 0;
    endfunction

    function automatic bit m_hazard(input int r);
        if (m_is_zero(r)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && int'(wr_addr) == r) return 1'b0;
`endif
        return m_busy[r];
    endfunction

    function automatic bit m_ready();
        return !(m_hazard(int'(iss_src_a)) || m_hazard(int'(iss_src_b)) || m_hazard(int'(iss_dst)));
    endfunction

    function automatic logic [DW-1:0] m_read(input int r);
        if (m_is_zero(r)) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && int'(wr_addr) == r) return wr_data;
`endif
        return m_regs[r];
    endfunction

    function automatic int m_pend();
        int n = 0;
        for (int r = 0; r < NR; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    function automatic logic [NR-1:0] m_busy_vec();
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Apply one clock edge to the model using the inputs held during that cycle.
    task automatic model_clock();
        bit rdy;
        rdy = m_ready();
        if (wr_en) begin
            if (!m_is_zero(int'(wr_addr))) m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (iss_valid && rdy && !m_is_zero(int'(iss_dst))) m_busy[iss_dst] = 1'b1;
    endtask

    // Compare all outputs against the model.
    task automatic compare();
        chk("rd_data_a", 64'(rd_data_a), 64'(m_read(int'(rd_addr_a))));
        chk("rd_data_b", 64'(rd_data_b), 64'(m_read(int'(rd_addr_b))));
        chk("iss_ready", 64'(iss_ready), 64'(m_ready()));
        chk("busy",      64'(busy),      64'(m_busy_vec()));
        chk("pend_cnt",  64'(pend_cnt),  64'(m_pend()));
    endtask

    task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd,
                         input bit iv, input int dst, input int sa, input int sb,
                         input int ra, input int rb);
        wr_en = we; wr_addr = AW'(wa); wr_data = wd;
        iss_valid = iv; iss_dst = AW'(dst); iss_src_a = AW'(sa); iss_src_b = AW'(sb);
        rd_addr_a = AW'(ra); rd_addr_b = AW'(rb);
    endtask

    task automatic idle();
        drive(0, 0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    // Entered shortly after a posedge; checks the cycle, clocks it, returns after the next posedge.
    task automatic cycle();
        #2 compare();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_rd_a", 64'(rd_data_a), 64'h0);
        chk("rst_rd_b", 64'(rd_data_b), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_pend", 64'(pend_cnt), 64'h0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int p_before;

    initial begin
        model_reset();
        idle();
        #2;
        chk("init_busy", 64'(busy), 64'h0);
        chk("init_pend", 64'(pend_cnt), 64'h0);
        chk("init_rd_a", 64'(rd_data_a), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write / read, zero register
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0); cycle();
        drive(0, 0, '0, 0, 0, 0, 0, 5, 5); #1;
        chk("r5_a", 64'(rd_data_a), 64'hDEADBEEF);
        chk("r5_b", 64'(rd_data_b), 64'hDEADBEEF);
        cycle();
        drive(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0); cycle();
        drive(0, 0, '0, 0, 0, 0, 0, 0, 5); #1;
        chk("r0_zero", 64'(rd_data_a), 64'h0);
        cycle();

        // RAW stall on r7
        drive(0, 0, '0, 1, 7, 0, 0, 0, 0); cycle();
        idle(); #1;
        chk("busy7", 64'(busy[7]), 64'h1);
        chk("pend1", 64'(pend_cnt), 64'h1);
        drive(0, 0, '0, 1, 8, 7, 0, 7, 0); #1;
        chk("raw_stall", 64'(iss_ready), 64'h0);
        cycle();
        drive(1, 7, 32'hA5A50007, 1, 8, 7, 0, 7, 0); #1;
`ifdef REGFILE_BYPASS_EN
        chk("raw_wb_ready", 64'(iss_ready), 64'h1);
        chk("raw_wb_fwd", 64'(rd_data_a), 64'hA5A50007);
        cycle();
`else
        chk("raw_wb_ready", 64'(iss_ready), 64'h0);
        chk("raw_wb_old", 64'(rd_data_a), 64'h0);
        cycle();
        drive(0, 0, '0, 1, 8, 7, 0, 7, 0); #1;
        chk("raw_next_ready", 64'(iss_ready), 64'h1);
        chk("raw_next_data", 64'(rd_data_a), 64'hA5A50007);
        cycle();
`endif

        // WAW on r9, zero destination
        drive(0, 0, '0, 1, 9, 0, 0, 0, 0); cycle();
        drive(0, 0, '0, 1, 9, 0, 0, 0, 0); #1;
        chk("waw_stall", 64'(iss_ready), 64'h0);
        cycle();
        drive(0, 0, '0, 1, 0, 0, 0, 0, 0); #1;
        chk("dst0_ready", 64'(iss_ready), 64'h1);
        cycle();
        idle(); #1;
        chk("busy0", 64'(busy[0]), 64'h0);

        // Same-cycle set/release on one index (preload + issue), then different indices
        drive(1, 3, 32'h33, 1, 3, 0, 0, 0, 0); cycle();
        idle(); #1;
        chk("same_busy3", 64'(busy[3]), 64'h1);
        p_before = m_pend();
        drive(1, 3, 32'h333, 1, 4, 0, 0, 0, 0); cycle();
        idle(); #1;
        chk("diff_pend", 64'(pend_cnt), 64'(p_before));
        chk("diff_busy4", 64'(busy[4]), 64'h1);
        chk("diff_busy3", 64'(busy[3]), 64'h0);

        // Async reset mid-run, then fill and drain
        drive(0, 0, '0, 0, 0, 0, 0, 5, 3);
        async_reset();
        for (int i = 1; i < NR; i++) begin
            drive(0, 0, '0, 1, i, 0, 0, 0, 0); cycle();
        end
        idle(); #1;
        chk("fill_pend", 64'(pend_cnt), 64'd31);
        for (int i = 1; i < NR; i++) begin
            drive(1, i, DW'($urandom), 0, 0, 0, 0, i, 0); cycle();
        end
        idle(); #1;
        chk("drain_pend", 64'(pend_cnt), 64'd0);
        cycle();

        // Randomized traffic with a mid-run reset
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                drive(0, 0, '0, 0, 0, 0, 0, $urandom_range(0, NR-1), 0);
                async_reset();
            end
            drive($urandom_range(0, 1) == 1, $urandom_range(0, NR-1), DW'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, NR-1),
                  $urandom_range(0, NR-1), $urandom_range(0, NR-1),
                  $urandom_range(0, NR-1), $urandom_range(0, NR-1));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
